// File: rtl/vga_quadrant_timing_if.sv
// Timing outputs from the VGA pixel-timing generator towards the colour mux.
// master drives the timing, slave consumes it.
interface vga_quadrant_timing_if;
  logic       pix_tick;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [1:0] quad_sel;
  logic       frame_start;

  modport master (
    output pix_tick, pix_x, pix_y, hsync, vsync, video_on, quad_sel, frame_start
  );

  modport slave (
    input pix_tick, pix_x, pix_y, hsync, vsync, video_on, quad_sel, frame_start
  );
endinterface

// File: rtl/vga_quadrant_timing.sv
// VGA pixel-timing generator: divides clk to the pixel rate, counts pixels/lines,
// decodes sync pulses, active video and the 2-bit quadrant select for the colour mux.
module vga_quadrant_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  vga_quadrant_timing_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_HALF     = 10'(H_ACTIVE / 2);
  localparam logic [9:0] V_HALF     = 10'(V_ACTIVE / 2);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic             frame_start_q, frame_start_d;

  logic tick;
  logic h_wrap;
  logic v_wrap;
  logic active;

  always_comb begin
    tick   = (div_cnt_q == DIV_LAST);
    h_wrap = (h_cnt_q == H_LAST);
    v_wrap = (v_cnt_q == V_LAST);

    div_cnt_d     = tick ? '0 : div_cnt_q + 1'b1;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;

    // frame_start is registered on the wrapping edge so it lines up with the
    // first clk that shows (0,0), and only that clk of the pixel period.
    if (tick) begin
      if (h_wrap) begin
        h_cnt_d = '0;
        if (v_wrap) begin
          v_cnt_d       = '0;
          frame_start_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

    vga.pix_x       = h_cnt_q;
    vga.pix_y       = v_cnt_q;
    vga.pix_tick    = 1'b0;
    vga.hsync       = 1'b1;
    vga.vsync       = 1'b1;
    vga.video_on    = 1'b0;
    vga.quad_sel    = 2'b00;
    vga.frame_start = 1'b0;

    if (!rst) begin
      vga.pix_tick    = tick;
      vga.hsync       = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
      vga.vsync       = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
      vga.video_on    = active;
      vga.quad_sel    = active ? {v_cnt_q >= V_HALF, h_cnt_q >= H_HALF} : 2'b00;
      vga.frame_start = frame_start_q;
    end
  end

endmodule

// File: tb/tb_vga_quadrant_timing.sv
// Directed bench for vga_quadrant_timing on a reduced 16x12 geometry (odd active sizes)
// so whole frames and wraps fit in a short run.
module tb_vga_quadrant_timing;

  localparam int HA = 9, HF = 2, HS = 3, HB = 2;   // H_TOTAL 16, hsync low 11..13
  localparam int VA = 7, VF = 1, VS = 2, VB = 2;   // V_TOTAL 12, vsync low 8..9
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int DIV = 2;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   hs_low_clk;
  int   vs_low_clk;
  int   fs_cnt;

  vga_quadrant_timing_if vif ();

  vga_quadrant_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_x"},     32'(vif.pix_x), 0);
    chk({tag, "_y"},     32'(vif.pix_y), 0);
    chk({tag, "_hsync"}, 32'(vif.hsync), 1);
    chk({tag, "_vsync"}, 32'(vif.vsync), 1);
    chk({tag, "_von"},   32'(vif.video_on), 0);
    chk({tag, "_quad"},  32'(vif.quad_sel), 0);
    chk({tag, "_tick"},  32'(vif.pix_tick), 0);
    chk({tag, "_fs"},    32'(vif.frame_start), 0);
  endtask

  // Expected outputs t clks after reset release, straight from the timing definition.
  task automatic chk_model(input int t);
    int p, ex, ey, evon, equad, ehs, evs, efs;
    p     = t / DIV;
    ex    = p % HT;
    ey    = (p / HT) % VT;
    evon  = (ex < HA && ey < VA) ? 1 : 0;
    equad = evon ? ((ey >= VA / 2) ? 2 : 0) + ((ex >= HA / 2) ? 1 : 0) : 0;
    ehs   = (ex >= HA + HF && ex < HA + HF + HS) ? 0 : 1;
    evs   = (ey >= VA + VF && ey < VA + VF + VS) ? 0 : 1;
    efs   = (p > 0 && p % (HT * VT) == 0 && t % DIV == 0) ? 1 : 0;
    chk($sformatf("tick_t%0d", t),  32'(vif.pix_tick), (t % DIV == DIV - 1) ? 1 : 0);
    chk($sformatf("x_t%0d", t),     32'(vif.pix_x), 32'(ex));
    chk($sformatf("y_t%0d", t),     32'(vif.pix_y), 32'(ey));
    chk($sformatf("hsync_t%0d", t), 32'(vif.hsync), 32'(ehs));
    chk($sformatf("vsync_t%0d", t), 32'(vif.vsync), 32'(evs));
    chk($sformatf("von_t%0d", t),   32'(vif.video_on), 32'(evon));
    chk($sformatf("quad_t%0d", t),  32'(vif.quad_sel), 32'(equad));
    chk($sformatf("fs_t%0d", t),    32'(vif.frame_start), 32'(efs));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;

    // Reset hold for 5 clk
    for (int i = 0; i < 5; i++) begin
      step();
      chk_reset_state($sformatf("rst_hold%0d", i));
    end

    rst = 1'b0;
    #1;
    hs_low_clk = 0;
    vs_low_clk = 0;
    fs_cnt     = 0;
    for (int t = 0; t <= 556; t++) begin
      if (t > 0) step();
      chk_model(t);
      if (t < HT * DIV && !vif.hsync) hs_low_clk++;
      if (t < HT * VT * DIV && !vif.vsync) vs_low_clk++;
      if (vif.frame_start) fs_cnt++;
      // hand-computed spot checks
      if (t == 1)  chk("first_tick", 32'(vif.pix_tick), 1);
      if (t == 9)  chk("step_x4", 32'(vif.pix_x), 4);
      if (t == 31) chk("line_end_xy", {vif.pix_y, 6'd0, vif.pix_x}, {10'd0, 6'd0, 10'd15});
      if (t == 32) chk("line_wrap_xy", {vif.pix_y, 6'd0, vif.pix_x}, {10'd1, 6'd0, 10'd0});
      if (t == 6)   chk("quad_3_0", 32'(vif.quad_sel), 2'b00);
      if (t == 8)   chk("quad_4_0_odd_boundary", 32'(vif.quad_sel), 2'b01);
      if (t == 102) chk("quad_3_3", 32'(vif.quad_sel), 2'b10);
      if (t == 208) chk("quad_8_6", 32'(vif.quad_sel), 2'b11);
      if (t == 50)  chk("von_9_1", {30'd0, vif.video_on, 1'b0} | 32'(vif.quad_sel), 0);
      if (t == 226) chk("von_1_7", {30'd0, vif.video_on, 1'b0} | 32'(vif.quad_sel), 0);
      if (t == 382) chk("frame_end_xy", {vif.pix_y, 6'd0, vif.pix_x}, {10'd11, 6'd0, 10'd15});
      if (t == 384) chk("frame_wrap_fs", {vif.pix_y, 5'd0, vif.frame_start, vif.pix_x}, {10'd0, 5'd0, 1'b1, 10'd0});
      if (t == 385) chk("frame_fs_one_clk", 32'(vif.frame_start), 0);
    end
    chk("hsync_low_clks", 32'(hs_low_clk), 32'(HS * DIV));
    chk("vsync_low_clks", 32'(vs_low_clk), 32'(VS * HT * DIV));
    chk("frame_start_count", 32'(fs_cnt), 1);
    chk("mid_point_xy", {vif.pix_y, 6'd0, vif.pix_x}, {10'd5, 6'd0, 10'd6});

    // Mid-frame reset for 1 clk
    rst = 1'b1;
    #1;
    chk("midrst_forced_von", 32'(vif.video_on), 0);
    step();
    chk_reset_state("midrst");
    rst = 1'b0;
    #1;
    for (int t = 0; t <= 40; t++) begin
      if (t > 0) step();
      chk_model(t);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_quadrant_timing.md
Name: vga_quadrant_timing

Overview:
Pixel-timing generator for the VGA controller; sits directly upstream of the 4-to-1 colour mux.
- Generates sync pulses, pixel coordinates and the active-video flag.
- Produces the 2-bit quadrant select that steers the mux between its four 24-bit colour inputs.
- Default geometry: 640x480 at 60 Hz, with the 50 MHz system clock divided down to the 25 MHz pixel rate.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (>=1)

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- pix_tick  out  1  one-clk pulse marking the last clk of each pixel period
- pix_x  out  10  horizontal counter, 0..H_TOTAL-1
- pix_y  out  10  vertical counter, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high while (pix_x, pix_y) is inside the active area
- quad_sel  out  2  quadrant select to the colour mux
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0)

Behaviour:
Derived constants:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525

Counters and state:
- Three registers: div_cnt (0..CLK_DIV-1), h_cnt, v_cnt.
- pix_x = h_cnt and pix_y = v_cnt, with no added latency.

Reset (rst sampled high at a clk edge):
- div_cnt, h_cnt and v_cnt clear to 0.
- While rst is high, outputs are forced to: pix_tick=0, hsync=1, vsync=1, video_on=0, quad_sel=00, frame_start=0.
- Reset mid-frame aborts the frame. The first pixel after rst falls is (0,0) with full div period.

Divider:
- div_cnt increments every clk and wraps at CLK_DIV-1.
- pix_tick = (div_cnt == CLK_DIV-1).
- If CLK_DIV = 1, pix_tick is constantly 1 outside reset.

Horizontal counter:
- Advances on clk only when pix_tick=1.
- If h_cnt == H_TOTAL-1, it wraps to 0 and v_cnt advances.

Vertical counter:
- If v_cnt == V_TOTAL-1 while h_cnt wraps, v_cnt wraps to 0.
- Both counters wrap on the same edge.

frame_start:
- Asserts for exactly one clk, the clk cycle in which h_cnt and v_cnt first show (0,0) after a wrap.
- Not asserted on the first frame after reset.

Decodes (combinational from the counter registers):
- hsync = 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync = 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).

Quadrant select:
- quad_sel = {v_cnt >= V_ACTIVE/2, h_cnt >= H_ACTIVE/2} when video_on=1; 00 otherwise.
- Mapping: 00 = top-left (first), 01 = top-right (second), 10 = bottom-left (third), 11 = bottom-right (fourth).
- Matches the mux input ordering r1..r4.

Boundary rules:
- Counters never exceed H_TOTAL-1 / V_TOTAL-1.
- Odd H_ACTIVE/V_ACTIVE use integer division; the boundary pixel goes to the right/bottom quadrant.

Timing totals (defaults):
- Line = 1600 clk.
- Frame = 840000 clk.

Test Plan:
- Reset hold: rst=1 for 5 clk -> pix_x=0, pix_y=0, hsync=1, vsync=1, video_on=0, quad_sel=00, pix_tick=0. After release, pix_tick first pulses on the 2nd clk.
- Pixel stepping: free-run 10 clk after reset -> pix_x increments once every 2 clk (0,0,1,1,…,4,4). pix_tick alternates 0/1.
- Horizontal timing: free-run one line -> hsync low exactly while pix_x 656..751 (192 clk). pix_x wraps 799->0 and pix_y 0->1 on the same edge.
- Quadrant decode: sample (319,0)->00; (320,0)->01; (319,240)->10; (639,479)->11; (640,100)->video_on=0, quad_sel=00; (100,480)->video_on=0, quad_sel=00.
- Frame wrap: free-run 840000 clk -> vsync low only for pix_y 490..491 (3200 clk). At (799,524) the next pixel is (0,0) and frame_start pulses for 1 clk.
- Mid-frame reset: assert rst at (400,300) for 1 clk -> next cycle (0,0), sync outputs high. No frame_start. Normal stepping resumes.
